// File: rtl/fetch_queue_pkg.sv
// Shared widths and constants for the fetch/decode decoupling queue.
package fetch_queue_pkg;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  // addi x0, x0, 0 -- also reused by decode and the hazard unit as the bubble instruction
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic int entry_width(input int aw, input int dw);
    return 2 * aw + dw;
  endfunction
endpackage

// File: rtl/fq_storage.sv
// Queue entry array: one synchronous write port, one asynchronous read port, no reset.
module fq_storage #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// Circular fetch->decode queue; flush drops all entries, if_ready depends only on registered count.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  input  logic [DATA_WIDTH-1:0] if_instr,
  input  logic [ADDR_WIDTH-1:0] if_pc_plus4,
  output logic                  if_ready,
  output logic                  id_valid,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [ADDR_WIDTH-1:0] id_pc_plus4,
  input  logic                  id_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = entry_width(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [EW-1:0] rdata;

  assign if_ready = (count != FULL);
  assign id_valid = (count != '0);
  assign push     = if_valid & if_ready & ~flush;
  assign pop      = id_valid & id_ready & ~flush;

  // Pointers wrap by natural overflow since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  fq_storage #(.DEPTH(DEPTH), .WIDTH(EW)) u_storage (
    .clk   (clk),
    .we    (push & ~rst),
    .waddr (wr_ptr),
    .wdata ({if_pc, if_instr, if_pc_plus4}),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Empty queue presents a NOP bubble so decode never sees stale storage.
  always_comb begin
    id_pc       = '0;
    id_instr    = DATA_WIDTH'(NOP_INSTR);
    id_pc_plus4 = '0;
    if (id_valid) begin
      {id_pc, id_instr, id_pc_plus4} = rdata;
    end
  end
endmodule
